tl45_register_read: RTL and testbench

- Register-read stage of the TL45 pipeline, directly upstream of the ALU stage.
- Owns the 16x32 architectural register file and resolves source operands from the register file, from the writeback port, or by forwarding from the ALU stage result.
- Detects load-use hazards and inserts bubbles.
- Presents a registered buffer (opcode, dr, sr1, sr2, sr1_val, sr2_val, pc) to the ALU stage, and chains stall/flush toward decode.

---
 rtl/tl45_register_read.sv | 163 ++++++++++++++++
 tb/tb_tl45_register_read.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tl45_register_read.sv
// TL45 register-read stage: owns the 16x32 register file, resolves source
// operands (register file, writeback write-through, ALU forwarding), inserts
// a single bubble on load-use hazards and presents a registered operand
// buffer to the ALU stage.
module tl45_register_read #(
  parameter int NREGS = 16,
  parameter int XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pipe_stall,
  input  logic            i_pipe_flush,
  output logic            o_pipe_stall,
  output logic            o_pipe_flush,
  input  logic [4:0]      i_opcode,
  input  logic [3:0]      i_dr,
  input  logic [3:0]      i_sr1,
  input  logic [3:0]      i_sr2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_imm_sel,
  input  logic [XLEN-1:0] i_pc,
  input  logic [3:0]      i_alu_dr,
  input  logic [XLEN-1:0] i_alu_val,
  input  logic            i_alu_is_load,
  input  logic            i_wb_en,
  input  logic [3:0]      i_wb_reg,
  input  logic [XLEN-1:0] i_wb_val,
  output logic [4:0]      o_opcode,
  output logic [3:0]      o_dr,
  output logic [3:0]      o_sr1,
  output logic [3:0]      o_sr2,
  output logic [XLEN-1:0] o_sr1_val,
  output logic [XLEN-1:0] o_sr2_val,
  output logic [XLEN-1:0] o_pc
);

  // Architectural register file; entry 0 is never written so it stays zero.
  logic [XLEN-1:0] rf [NREGS];

  // Combinationally resolved operands and hazard for the incoming instruction.
  logic [XLEN-1:0] sr1_val_c;
  logic [XLEN-1:0] sr2_val_c;
  logic            hazard;

  // Output buffer towards the ALU stage.
  logic [4:0]      opcode_p0;
  logic [3:0]      dr_p0;
  logic [3:0]      sr1_p0;
  logic [3:0]      sr2_p0;
  logic [XLEN-1:0] sr1_val_p0;
  logic [XLEN-1:0] sr2_val_p0;
  logic [XLEN-1:0] pc_p0;

  // Operand source selection, first match wins: r0, ALU forward (only when
  // the ALU value is real, i.e. not a pending load), same-cycle writeback,
  // then the register file.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [3:0]      src,
    input logic [XLEN-1:0] rf_val,
    input logic [3:0]      alu_dr,
    input logic [XLEN-1:0] alu_val,
    input logic            alu_is_load,
    input logic            wb_en,
    input logic [3:0]      wb_reg,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] val;
    if (src == 4'd0) begin
      val = '0;
    end else if (src == alu_dr && alu_dr != 4'd0 && !alu_is_load) begin
      val = alu_val;
    end else if (wb_en && src == wb_reg) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // Register file write port; writeback is never blocked by stall or flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (i_wb_en && i_wb_reg != 4'd0) begin
      rf[i_wb_reg] <= i_wb_val;
    end
  end

  // Operand resolution; an immediate replaces sr2 entirely.
  always_comb begin
    sr1_val_c = resolve_operand(i_sr1, rf[i_sr1], i_alu_dr, i_alu_val,
                                i_alu_is_load, i_wb_en, i_wb_reg, i_wb_val);
    sr2_val_c = resolve_operand(i_sr2, rf[i_sr2], i_alu_dr, i_alu_val,
                                i_alu_is_load, i_wb_en, i_wb_reg, i_wb_val);
    if (i_imm_sel) begin
      sr2_val_c = i_imm;
    end
  end

  // Load-use detection: the ALU holds a load whose result a real source of
  // this (non-NOP) instruction needs; sr2 is ignored when the immediate is used.
  always_comb begin
    hazard = 1'b0;
    if (i_alu_is_load && i_alu_dr != 4'd0 && i_opcode != 5'd0) begin
      hazard = (i_sr1 == i_alu_dr) || (!i_imm_sel && i_sr2 == i_alu_dr);
    end
  end

  // Stall/flush chaining towards decode.
  always_comb begin
    o_pipe_stall = i_pipe_stall || hazard;
    o_pipe_flush = i_pipe_flush;
  end

  // ---- stage boundary: register read -> ALU buffer ----
  // Buffer update: flush beats stall, stall holds, hazard injects a bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_pipe_flush) begin
      opcode_p0  <= '0;
      dr_p0      <= '0;
      sr1_p0     <= '0;
      sr2_p0     <= '0;
      sr1_val_p0 <= '0;
      sr2_val_p0 <= '0;
      pc_p0      <= '0;
    end else if (i_pipe_stall) begin
      opcode_p0  <= opcode_p0;
      dr_p0      <= dr_p0;
      sr1_p0     <= sr1_p0;
      sr2_p0     <= sr2_p0;
      sr1_val_p0 <= sr1_val_p0;
      sr2_val_p0 <= sr2_val_p0;
      pc_p0      <= pc_p0;
    end else if (hazard) begin
      opcode_p0  <= '0;
      dr_p0      <= '0;
      sr1_p0     <= '0;
      sr2_p0     <= '0;
      sr1_val_p0 <= '0;
      sr2_val_p0 <= '0;
      pc_p0      <= '0;
    end else begin
      opcode_p0  <= i_opcode;
      dr_p0      <= i_dr;
      sr1_p0     <= i_sr1;
      sr2_p0     <= i_sr2;
      sr1_val_p0 <= sr1_val_c;
      sr2_val_p0 <= sr2_val_c;
      pc_p0      <= i_pc;
    end
  end

  assign o_opcode  = opcode_p0;
  assign o_dr      = dr_p0;
  assign o_sr1     = sr1_p0;
  assign o_sr2     = sr2_p0;
  assign o_sr1_val = sr1_val_p0;
  assign o_sr2_val = sr2_val_p0;
  assign o_pc      = pc_p0;

endmodule

// File: tb/tb_tl45_register_read.sv
// Randomized bench for tl45_register_read against a behavioural model of the
// register-read stage (array register file plus an expected output buffer).
module tb_tl45_register_read;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_stall, pipe_flush;
  logic        o_stall, o_flush;
  logic [4:0]  opcode;
  logic [3:0]  dr, sr1, sr2;
  logic [31:0] imm;
  logic        imm_sel;
  logic [31:0] pc;
  logic [3:0]  alu_dr;
  logic [31:0] alu_val;
  logic        alu_is_load;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_val;
  logic [4:0]  q_opcode;
  logic [3:0]  q_dr, q_sr1, q_sr2;
  logic [31:0] q_sr1_val, q_sr2_val, q_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state.
  logic [31:0] m_rf [16];
  logic [4:0]  e_opcode;
  logic [3:0]  e_dr, e_sr1, e_sr2;
  logic [31:0] e_sr1_val, e_sr2_val, e_pc;

  always #5 clk = ~clk;

  tl45_register_read dut (
    .i_clk(clk), .i_reset(rst),
    .i_pipe_stall(pipe_stall), .i_pipe_flush(pipe_flush),
    .o_pipe_stall(o_stall), .o_pipe_flush(o_flush),
    .i_opcode(opcode), .i_dr(dr), .i_sr1(sr1), .i_sr2(sr2),
    .i_imm(imm), .i_imm_sel(imm_sel), .i_pc(pc),
    .i_alu_dr(alu_dr), .i_alu_val(alu_val), .i_alu_is_load(alu_is_load),
    .i_wb_en(wb_en), .i_wb_reg(wb_reg), .i_wb_val(wb_val),
    .o_opcode(q_opcode), .o_dr(q_dr), .o_sr1(q_sr1), .o_sr2(q_sr2),
    .o_sr1_val(q_sr1_val), .o_sr2_val(q_sr2_val), .o_pc(q_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Where the value of source s comes from in the current cycle.
  function automatic logic [31:0] m_operand(input logic [3:0] s);
    if (s == 0) return 32'd0;
    if (!alu_is_load && alu_dr != 0 && s == alu_dr) return alu_val;
    if (wb_en && s == wb_reg) return wb_val;
    return m_rf[s];
  endfunction

  function automatic logic m_hazard();
    if (!alu_is_load || alu_dr == 0 || opcode == 0) return 1'b0;
    return (sr1 == alu_dr) || (!imm_sel && sr2 == alu_dr);
  endfunction

  task automatic idle();
    rst = 0; pipe_stall = 0; pipe_flush = 0;
    opcode = 0; dr = 0; sr1 = 0; sr2 = 0; imm = 0; imm_sel = 0; pc = 0;
    alu_dr = 0; alu_val = 0; alu_is_load = 0;
    wb_en = 0; wb_reg = 0; wb_val = 0;
  endtask

  // One clock: inputs already driven (after a negedge). Check the
  // combinational chaining, advance the model, then check the buffer.
  task automatic cycle();
    logic        haz;
    logic [31:0] v1, v2;
    #1;
    haz = m_hazard();
    check("o_pipe_stall", {31'd0, o_stall}, {31'd0, pipe_stall | haz});
    check("o_pipe_flush", {31'd0, o_flush}, {31'd0, pipe_flush});
    v1 = m_operand(sr1);
    v2 = imm_sel ? imm : m_operand(sr2);
    if (rst || pipe_flush || (!pipe_stall && haz)) begin
      e_opcode = 0; e_dr = 0; e_sr1 = 0; e_sr2 = 0;
      e_sr1_val = 0; e_sr2_val = 0; e_pc = 0;
    end else if (!pipe_stall) begin
      e_opcode = opcode; e_dr = dr; e_sr1 = sr1; e_sr2 = sr2;
      e_sr1_val = v1; e_sr2_val = v2; e_pc = pc;
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
    end else if (wb_en && wb_reg != 0) begin
      m_rf[wb_reg] = wb_val;
    end
    @(posedge clk);
    #1;
    check("o_opcode",  {27'd0, q_opcode}, {27'd0, e_opcode});
    check("o_dr",      {28'd0, q_dr},     {28'd0, e_dr});
    check("o_sr1",     {28'd0, q_sr1},    {28'd0, e_sr1});
    check("o_sr2",     {28'd0, q_sr2},    {28'd0, e_sr2});
    check("o_sr1_val", q_sr1_val, e_sr1_val);
    check("o_sr2_val", q_sr2_val, e_sr2_val);
    check("o_pc",      q_pc,      e_pc);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 32'hX;
    e_opcode = 'x; e_dr = 'x; e_sr1 = 'x; e_sr2 = 'x;
    e_sr1_val = 'x; e_sr2_val = 'x; e_pc = 'x;
    idle();
    @(negedge clk);

    // Reset, then read every register.
    rst = 1; cycle(); idle();
    for (int r = 0; r < 16; r++) begin
      opcode = 1; sr1 = 4'(r); sr2 = 4'(15 - r); pc = 32'(r * 4);
      cycle();
      check("rst_rd_sr1", q_sr1_val, 32'd0);
    end
    idle(); wb_en = 1; wb_reg = 0; wb_val = 32'hDEADBEEF; cycle();
    idle(); opcode = 1; sr1 = 0; cycle();
    check("r0_zero", q_sr1_val, 32'd0);

    // Writeback, then read; same-cycle write-through.
    idle(); wb_en = 1; wb_reg = 3; wb_val = 32'h12345678; cycle();
    idle(); opcode = 1; sr1 = 3; sr2 = 3; cycle();
    check("rf_sr1", q_sr1_val, 32'h12345678);
    check("rf_sr2", q_sr2_val, 32'h12345678);
    idle(); opcode = 1; sr1 = 5; wb_en = 1; wb_reg = 5; wb_val = 32'hA5; cycle();
    check("wthru", q_sr1_val, 32'hA5);

    // ALU forwarding beats writeback and register file.
    idle(); wb_en = 1; wb_reg = 4; wb_val = 32'h300; cycle();
    idle(); opcode = 1; sr1 = 4; alu_dr = 4; alu_val = 32'h100;
    wb_en = 1; wb_reg = 4; wb_val = 32'h200; cycle();
    check("alu_fwd", q_sr1_val, 32'h100);

    // Load-use: one bubble, then re-resolve from writeback.
    idle(); opcode = 3; sr1 = 2; alu_dr = 2; alu_is_load = 1; pc = 32'h40;
    #1 check("lu_stall", {31'd0, o_stall}, 32'd1);
    cycle();
    check("lu_bubble", {27'd0, q_opcode}, 32'd0);
    idle(); opcode = 3; sr1 = 2; pc = 32'h40; wb_en = 1; wb_reg = 2; wb_val = 32'h55;
    #1 check("lu_nostall", {31'd0, o_stall}, 32'd0);
    cycle();
    check("lu_val", q_sr1_val, 32'h55);

    // Stall holds for three cycles while inputs change, then flush wins.
    for (int k = 0; k < 3; k++) begin
      idle(); pipe_stall = 1; opcode = 5'(k + 7); sr1 = 4'(k + 1); pc = $urandom;
      wb_en = 1; wb_reg = 2; wb_val = $urandom;
      cycle();
      check("stall_hold", q_pc, 32'h40);
    end
    idle(); pipe_stall = 1; pipe_flush = 1; opcode = 9; cycle();
    check("flush_nop", {27'd0, q_opcode}, 32'd0);

    // Immediate on sr2 hides a would-be load-use on sr2.
    idle(); opcode = 2; sr1 = 1; sr2 = 6; alu_dr = 6; alu_is_load = 1;
    imm_sel = 1; imm = 32'hFFFFFFF0;
    #1 check("imm_nostall", {31'd0, o_stall}, 32'd0);
    cycle();
    check("imm_val", q_sr2_val, 32'hFFFFFFF0);

    // Reset mid-stall with a pending hazard.
    idle(); pipe_stall = 1; rst = 1; opcode = 3; sr1 = 2; alu_dr = 2; alu_is_load = 1;
    cycle();

    // Randomized traffic over a narrow index range to provoke interactions.
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      pipe_stall  = ($urandom_range(0, 7) == 0);
      pipe_flush  = ($urandom_range(0, 15) == 0);
      opcode      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      dr          = 4'($urandom);
      sr1         = 4'($urandom_range(0, 5));
      sr2         = 4'($urandom_range(0, 5));
      imm         = $urandom;
      imm_sel     = ($urandom_range(0, 3) == 0);
      pc          = $urandom;
      alu_dr      = 4'($urandom_range(0, 5));
      alu_val     = $urandom;
      alu_is_load = ($urandom_range(0, 2) == 0);
      wb_en       = ($urandom_range(0, 1) == 0);
      wb_reg      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      wb_val      = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
